// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB3 bridge.
// Takes single AHB transfers and runs each one as an APB SETUP/ACCESS
// sequence on one of PSEL_NUM peripherals. APB or transfer errors are
// returned as the AHB two-cycle ERROR response.
module ahb_apb_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PSEL_NUM   = 4,
  parameter int SEL_LSB    = 12
) (
  input  logic                  HCLK,
  input  logic                  HRST,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [PSEL_NUM-1:0]   PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int IDX_W = (PSEL_NUM > 1) ? $clog2(PSEL_NUM) : 1;
  localparam int BUS_BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [IDX_W-1:0]      index_q;

  logic [IDX_W-1:0]      hindex;
  logic                  accept;
  logic                  illegal;
  logic                  accept_state;
  logic                  take;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [IDX_W-1:0]      req_index;
  logic                  trans_unused;

  // HTRANS[0] only separates SEQ from NONSEQ and BUSY from IDLE, which the bridge treats alike
  assign trans_unused = HTRANS[0];

  assign hindex       = HADDR[SEL_LSB +: IDX_W];
  assign accept       = HSEL & HREADY & HTRANS[1];
  assign illegal      = ((32'd1 << HSIZE) > 32'(BUS_BYTES)) || (32'(hindex) >= 32'(PSEL_NUM));
  assign accept_state = (state == S_IDLE) || (state == S_ERR2);
  assign take         = accept_state & accept;

  // A read goes straight from the address phase to SETUP, so it uses the live bus values
  always_comb begin
    req_addr  = addr_q;
    req_write = write_q;
    req_index = index_q;
    if (accept_state) begin
      req_addr  = HADDR;
      req_write = HWRITE;
      req_index = hindex;
    end
  end

  // Next-state logic; IDLE and ERR2 both evaluate a new address phase
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ERR2: begin
        if (accept) begin
          if (illegal)     state_nxt = S_ERR1;
          else if (HWRITE) state_nxt = S_WDATA;
          else             state_nxt = S_SETUP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WDATA:  state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) state_nxt = PSLVERR ? S_ERR1 : S_IDLE;
      end
      S_ERR1:   state_nxt = S_ERR2;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge HCLK) begin
    if (HRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Remember the accepted request for the later phases of a write
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      index_q <= '0;
    end else if (take) begin
      addr_q  <= HADDR;
      write_q <= HWRITE;
      index_q <= hindex;
    end
  end

  // AHB response outputs are registered from the state being entered
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
    end else begin
      HREADYOUT <= (state_nxt == S_IDLE) || (state_nxt == S_ERR2);
      HRESP     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
      if ((state == S_ACCESS) && PREADY && !PSLVERR && !write_q)
        HRDATA <= PRDATA;
    end
  end

  // APB outputs; address and direction only change when a new SETUP begins
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWDATA  <= '0;
    end else begin
      PENABLE <= (state_nxt == S_ACCESS);
      if (state_nxt == S_SETUP) begin
        PADDR  <= req_addr;
        PWRITE <= req_write;
        PSEL   <= PSEL_NUM'(1) << req_index;
      end else if (state_nxt != S_ACCESS) begin
        PSEL   <= '0;
      end
      if (state == S_WDATA)
        PWDATA <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: directed vector table, hand-written
// corner sequences and randomized transfers against a transaction-level model.
module tb_ahb_apb_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int PN = 4;

  logic          HCLK = 1'b0;
  logic          HRST;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [1:0]    HTRANS;
  logic          HREADY;
  logic [DW-1:0] HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [DW-1:0] HRDATA;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [PN-1:0] PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int testsRun = 0;
  int testsFailed = 0;

  // APB slave model configuration
  int          waitCfg = 0;
  logic        errCfg = 1'b0;
  logic [31:0] rdCfg = '0;
  int          accCnt = 0;

  // Observations from the last transfer
  int          obsWait;
  logic        obsResp;
  logic [3:0]  obsPsel;
  logic [31:0] obsPaddr;
  logic        obsPwrite;
  logic [31:0] obsPwdata;
  int          obsSetup;
  logic        obsMulti;

  logic [31:0] modelHrdata;

  ahb_apb_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PSEL_NUM(PN), .SEL_LSB(12)) dut (
    .HCLK(HCLK), .HRST(HRST), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  // The bridge is the only slave on this bus, so the bus-wide ready is its own
  assign HREADY  = HREADYOUT;
  assign PREADY  = (PSEL != '0) && PENABLE && (accCnt >= waitCfg);
  assign PSLVERR = errCfg && PREADY;
  assign PRDATA  = rdCfg;

  always @(posedge HCLK) begin
    if (HRST || !PENABLE) accCnt <= 0;
    else if (!PREADY)     accCnt <= accCnt + 1;
  end

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    int          expWait;
    logic        expResp;
    logic [31:0] expHrdata;
    logic [3:0]  expPsel;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Run one complete AHB transfer and record what the bridge did
  task automatic applyStimulus(input logic [31:0] addr, input logic write, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int waits, input logic err);
    waitCfg = waits; errCfg = err; rdCfg = rdata;
    obsWait = 0; obsPsel = '0; obsPaddr = '0; obsPwrite = 1'b0; obsPwdata = '0;
    obsSetup = 0; obsMulti = 1'b0;
    HSEL = 1'b1; HADDR = addr; HWRITE = write; HSIZE = size; HTRANS = 2'd2;
    tick();
    HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = $urandom; HWDATA = wdata;
    while (!HREADYOUT && obsWait < 64) begin
      obsWait++;
      if ($countones(PSEL) > 1) obsMulti = 1'b1;
      if (PSEL != '0 && !PENABLE) obsSetup++;
      if (PSEL != '0 && PENABLE) begin
        obsPsel = PSEL; obsPaddr = PADDR; obsPwrite = PWRITE; obsPwdata = PWDATA;
      end
      tick();
    end
    obsResp = HRESP;
    tick();
  endtask

  task automatic checkTransfer(input int expWait, input logic expResp, input logic [31:0] expHrdata,
                               input logic [3:0] expPsel, input logic [31:0] addr,
                               input logic write, input logic [31:0] wdata);
    checkOutput("waitStates", obsWait, expWait);
    checkOutput("hresp", {31'd0, obsResp}, {31'd0, expResp});
    checkOutput("hrdata", HRDATA, expHrdata);
    checkOutput("psel", {28'd0, obsPsel}, {28'd0, expPsel});
    checkOutput("pselOneHot", {31'd0, obsMulti}, 32'd0);
    if (expPsel != '0) begin
      checkOutput("paddr", obsPaddr, addr);
      checkOutput("pwrite", {31'd0, obsPwrite}, {31'd0, write});
      checkOutput("setupCycles", obsSetup, 1);
      if (write) checkOutput("pwdata", obsPwdata, wdata);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] rd;
    int          wt;
    logic        er;
    logic        bad;
    int          expWait;
    int          guard;

    vecs[0] = '{32'h0000_1010, 1'b0, 3'd2, 32'h0,          32'hDEADBEEF, 0, 1'b0, 2, 1'b0, 32'hDEADBEEF, 4'b0010};
    vecs[1] = '{32'h0000_3004, 1'b1, 3'd2, 32'h12345678,   32'h0,        3, 1'b0, 6, 1'b0, 32'hDEADBEEF, 4'b1000};
    vecs[2] = '{32'h0000_2000, 1'b0, 3'd2, 32'h0,          32'h11111111, 0, 1'b1, 3, 1'b1, 32'hDEADBEEF, 4'b0100};
    vecs[3] = '{32'h0000_3000, 1'b0, 3'd3, 32'h0,          32'h22222222, 0, 1'b0, 1, 1'b1, 32'hDEADBEEF, 4'b0000};
    vecs[4] = '{32'h0000_0008, 1'b1, 3'd1, 32'h0000A5A5,   32'h0,        1, 1'b1, 5, 1'b1, 32'hDEADBEEF, 4'b0001};
    vecs[5] = '{32'h0000_1FFC, 1'b0, 3'd2, 32'h0,          32'hCAFEF00D, 2, 1'b0, 4, 1'b0, 32'hCAFEF00D, 4'b0010};

    HRST = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2; HTRANS = 2'd0; HWDATA = '0;
    tick(); tick();
    HRST = 1'b0;
    tick();
    checkOutput("rstHreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("rstHresp", {31'd0, HRESP}, 32'd0);
    checkOutput("rstPsel", {28'd0, PSEL}, 32'd0);
    checkOutput("rstPenable", {31'd0, PENABLE}, 32'd0);
    checkOutput("rstHrdata", HRDATA, 32'd0);
    checkOutput("rstPaddr", PADDR, 32'd0);
    checkOutput("rstPwdata", PWDATA, 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].write, vecs[i].size, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].waits, vecs[i].err);
      checkTransfer(vecs[i].expWait, vecs[i].expResp, vecs[i].expHrdata, vecs[i].expPsel,
                    vecs[i].addr, vecs[i].write, vecs[i].wdata);
    end

    // Reset held for two cycles while the APB slave is stalling in ACCESS
    waitCfg = 20; errCfg = 1'b0; rdCfg = 32'h55AA55AA;
    HSEL = 1'b1; HADDR = 32'h0000_1000; HWRITE = 1'b0; HSIZE = 3'd2; HTRANS = 2'd2;
    tick();
    HSEL = 1'b0; HTRANS = 2'd0;
    guard = 0;
    while (!PENABLE && guard < 10) begin
      guard++;
      tick();
    end
    checkOutput("midAccessReached", {31'd0, PENABLE}, 32'd1);
    HRST = 1'b1;
    tick(); tick();
    HRST = 1'b0;
    tick();
    checkOutput("midRstHreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("midRstHresp", {31'd0, HRESP}, 32'd0);
    checkOutput("midRstPsel", {28'd0, PSEL}, 32'd0);
    checkOutput("midRstPenable", {31'd0, PENABLE}, 32'd0);
    checkOutput("midRstHrdata", HRDATA, 32'd0);
    modelHrdata = 32'd0;

    // Illegal size, then a read presented during ERR2 must be taken straight away
    waitCfg = 0; errCfg = 1'b0; rdCfg = 32'h600DF00D;
    HSEL = 1'b1; HADDR = 32'h0000_1000; HWRITE = 1'b0; HSIZE = 3'd3; HTRANS = 2'd2;
    tick();
    HSEL = 1'b0; HTRANS = 2'd0; HSIZE = 3'd2;
    checkOutput("err1Hreadyout", {31'd0, HREADYOUT}, 32'd0);
    checkOutput("err1Hresp", {31'd0, HRESP}, 32'd1);
    checkOutput("err1Psel", {28'd0, PSEL}, 32'd0);
    tick();
    checkOutput("err2Hreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("err2Hresp", {31'd0, HRESP}, 32'd1);
    checkOutput("err2Psel", {28'd0, PSEL}, 32'd0);
    HSEL = 1'b1; HADDR = 32'h0000_1000; HWRITE = 1'b0; HSIZE = 3'd2; HTRANS = 2'd2;
    tick();
    HSEL = 1'b0; HTRANS = 2'd0;
    checkOutput("b2bSetupPsel", {28'd0, PSEL}, 32'b0010);
    checkOutput("b2bSetupPenable", {31'd0, PENABLE}, 32'd0);
    checkOutput("b2bSetupHreadyout", {31'd0, HREADYOUT}, 32'd0);
    checkOutput("b2bSetupHresp", {31'd0, HRESP}, 32'd0);
    tick();
    checkOutput("b2bAccessPenable", {31'd0, PENABLE}, 32'd1);
    tick();
    checkOutput("b2bDoneHreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("b2bDoneHrdata", HRDATA, 32'h600DF00D);
    checkOutput("b2bDonePsel", {28'd0, PSEL}, 32'd0);
    modelHrdata = 32'h600DF00D;

    // IDLE and BUSY transfers, and an unselected NONSEQ, must all be ignored
    for (int t = 0; t < 3; t++) begin
      HSEL = (t < 2); HTRANS = (t < 2) ? 2'(t) : 2'd2; HADDR = 32'h0000_2000; HWRITE = 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        checkOutput("filterHreadyout", {31'd0, HREADYOUT}, 32'd1);
        checkOutput("filterHresp", {31'd0, HRESP}, 32'd0);
        checkOutput("filterPsel", {28'd0, PSEL}, 32'd0);
      end
    end
    HSEL = 1'b0; HTRANS = 2'd0;
    tick();

    // Randomized transfers against a transaction-level model
    for (int n = 0; n < 40; n++) begin
      a  = $urandom;
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 3));
      wd = $urandom;
      rd = $urandom;
      wt = $urandom_range(0, 3);
      er = ($urandom_range(0, 4) == 0);
      bad = ((1 << sz) > DW / 8);
      if (bad) expWait = 1;
      else     expWait = (w ? 3 : 2) + wt + (er ? 1 : 0);
      if (!bad && !er && !w) modelHrdata = rd;
      applyStimulus(a, w, sz, wd, rd, wt, er);
      checkTransfer(expWait, bad | er, modelHrdata, bad ? 4'b0000 : (4'b0001 << a[13:12]), a, w, wd);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
